// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - Shared CSR command and error types
//
// Purpose: types shared between the CSR access unit, its requester and the
//          CSR file.
//   ControlRegisterCommand : N (no-op), R (read), W (write), S (set bits),
//                            C (clear bits).
//   CsrErr                 : response status returned with each transaction.
//   cmd_writes()           : true for commands that modify the CSR.
package Bundle;

  typedef enum logic [2:0] {
    CMD_N = 3'd0,
    CMD_R = 3'd1,
    CMD_W = 3'd2,
    CMD_S = 3'd3,
    CMD_C = 3'd4
  } ControlRegisterCommand;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_RD_ILL  = 2'd1,
    ERR_WR_ILL  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } CsrErr;

  function automatic logic cmd_writes(input ControlRegisterCommand cmd);
    return (cmd == CMD_W) || (cmd == CMD_S) || (cmd == CMD_C);
  endfunction

endpackage

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Single-outstanding CSR access sequencer
//
// Purpose: accepts one CSR operation at a time, checks its legality against
//          the CSR file, issues it (tolerating a bounded stall) and returns
//          the old CSR value or an error code.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_cmd/req_addr/req_wdata      operation, 12-bit address, operand
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err               old CSR value (0 on error), status
//   csr_cmd/csr_addr/csr_wdata      command/address/operand to CSR file
//   csr_rdata                       CSR file read data
//   csr_stall                       CSR file cannot commit this cycle
//   csr_read_illegal/write_illegal  legality of the address on csr_addr
module csr_access_unit
  import Bundle::*;
#(
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  ControlRegisterCommand req_cmd,
  input  logic [11:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output CsrErr                 rsp_err,
  output ControlRegisterCommand csr_cmd,
  output logic [11:0]           csr_addr,
  output logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_rdata,
  input  logic                  csr_stall,
  input  logic                  csr_read_illegal,
  input  logic                  csr_write_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] STALL_LIMIT = 8'(STALL_TIMEOUT);

  state_e                state_q,     state_d;
  ControlRegisterCommand cmd_q,       cmd_d;
  logic [7:0]            stall_cnt_q, stall_cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  CsrErr                 rsp_err_q,   rsp_err_d;
  ControlRegisterCommand csr_cmd_q,   csr_cmd_d;
  logic [11:0]           csr_addr_q,  csr_addr_d;
  logic [31:0]           csr_wdata_q, csr_wdata_d;

  ControlRegisterCommand cmd_accept;
  logic [7:0]            stall_inc;

  // Set/clear with a zero mask cannot change the CSR, so they are treated as
  // plain reads: no write side effect and no write-legality check.
  always_comb begin
    cmd_accept = req_cmd;
    if (((req_cmd == CMD_S) || (req_cmd == CMD_C)) && (req_wdata == 32'd0)) begin
      cmd_accept = CMD_R;
    end
  end

  assign stall_inc = stall_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    stall_cnt_d = stall_cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    csr_cmd_d   = csr_cmd_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d       = cmd_accept;
          csr_addr_d  = req_addr;
          csr_wdata_d = req_wdata;
          req_ready_d = 1'b0;
          if (cmd_accept == CMD_N) begin
            // A no-op never touches the CSR file.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = ERR_OK;
          end else begin
            state_d     = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        // csr_addr already shows the latched address; the CSR file answers
        // legality combinationally while csr_cmd is still N.
        if (csr_read_illegal) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = ERR_RD_ILL;
        end else if (cmd_writes(cmd_q) && csr_write_illegal) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = ERR_WR_ILL;
        end else begin
          state_d     = ST_ISSUE;
          stall_cnt_d = 8'd0;
          csr_cmd_d   = cmd_q;
        end
      end

      ST_ISSUE: begin
        if (!csr_stall) begin
          // Commit cycle: the CSR file returns the pre-update value now.
          state_d     = ST_RESP;
          csr_cmd_d   = CMD_N;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = csr_rdata;
          rsp_err_d   = ERR_OK;
        end else if (stall_inc == STALL_LIMIT) begin
          state_d     = ST_RESP;
          csr_cmd_d   = CMD_N;
          stall_cnt_d = stall_inc;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          stall_cnt_d = stall_inc;
        end
      end

      ST_RESP: begin
        // req_ready rises one cycle after the handshake, so a new request
        // cannot overlap the response being consumed.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        csr_cmd_d   = CMD_N;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_N;
      stall_cnt_q <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= ERR_OK;
      csr_cmd_q   <= CMD_N;
      csr_addr_q  <= 12'd0;
      csr_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      stall_cnt_q <= stall_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      csr_cmd_q   <= csr_cmd_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign csr_cmd   = csr_cmd_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - Directed self-checking bench for csr_access_unit
module tb_csr_access_unit;
  import Bundle::*;

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  ControlRegisterCommand req_cmd;
  logic [11:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  CsrErr                 rsp_err;
  ControlRegisterCommand csr_cmd;
  logic [11:0]           csr_addr;
  logic [31:0]           csr_wdata;
  logic [31:0]           csr_rdata;
  logic                  csr_stall;
  logic                  csr_read_illegal;
  logic                  csr_write_illegal;

  int n_cmp;
  int n_bad;

  csr_access_unit #(.STALL_TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_cmd           (req_cmd),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .csr_cmd           (csr_cmd),
    .csr_addr          (csr_addr),
    .csr_wdata         (csr_wdata),
    .csr_rdata         (csr_rdata),
    .csr_stall         (csr_stall),
    .csr_read_illegal  (csr_read_illegal),
    .csr_write_illegal (csr_write_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== ERR_OK) begin n_bad++; $display("FAIL rst_rsp_err: got %0d want 0", rsp_err); end
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL rst_csr_cmd: got %0d want 0", csr_cmd); end
    n_cmp++; if (csr_addr !== 12'd0) begin n_bad++; $display("FAIL rst_csr_addr: got %h want 0", csr_addr); end
    n_cmp++; if (csr_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_csr_wdata: got %h want 0", csr_wdata); end
    rst_n = 1'b1;
    tick;
  endtask

  // R to 0x300, no stall: commit in cycle 2, response in cycle 3.
  task automatic test_read;
    req_valid = 1'b1; req_cmd = CMD_R; req_addr = 12'h300; req_wdata = 32'd0;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready_c0: got %b want 1", req_ready); end
    tick; req_valid = 1'b0;
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL rd_check_cmd: got %0d want 0", csr_cmd); end
    n_cmp++; if (csr_addr !== 12'h300) begin n_bad++; $display("FAIL rd_check_addr: got %h want 300", csr_addr); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rd_busy_ready: got %b want 0", req_ready); end
    tick; csr_rdata = 32'h1800;
    n_cmp++; if (csr_cmd !== CMD_R) begin n_bad++; $display("FAIL rd_issue_cmd: got %0d want 1", csr_cmd); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_issue_rsp_valid: got %b want 0", rsp_valid); end
    tick; csr_rdata = 32'd0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid_c3: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h1800) begin n_bad++; $display("FAIL rd_rsp_rdata: got %h want 00001800", rsp_rdata); end
    n_cmp++; if (rsp_err !== ERR_OK) begin n_bad++; $display("FAIL rd_rsp_err: got %0d want 0", rsp_err); end
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL rd_one_commit: got %0d want 0", csr_cmd); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_after_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_after_ready: got %b want 1", req_ready); end
  endtask

  // W to 0xF11 rejected by the CSR file; csr_cmd must stay N throughout.
  task automatic test_write_illegal;
    req_valid = 1'b1; req_cmd = CMD_W; req_addr = 12'hF11; req_wdata = 32'hABCD;
    tick; req_valid = 1'b0; csr_write_illegal = 1'b1;
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL wi_check_cmd: got %0d want 0", csr_cmd); end
    tick; csr_write_illegal = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wi_rsp_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_err !== ERR_WR_ILL) begin n_bad++; $display("FAIL wi_rsp_err: got %0d want 2", rsp_err); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL wi_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL wi_resp_cmd: got %0d want 0", csr_cmd); end
    tick;
  endtask

  // Both illegal flags: read-illegal takes priority.
  task automatic test_read_illegal_priority;
    req_valid = 1'b1; req_cmd = CMD_W; req_addr = 12'h7C0; req_wdata = 32'h1;
    tick; req_valid = 1'b0; csr_read_illegal = 1'b1; csr_write_illegal = 1'b1;
    tick; csr_read_illegal = 1'b0; csr_write_illegal = 1'b0;
    n_cmp++; if (rsp_err !== ERR_RD_ILL) begin n_bad++; $display("FAIL ri_rsp_err: got %0d want 1", rsp_err); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL ri_rsp_valid: got %b want 1", rsp_valid); end
    tick;
  endtask

  // S with a zero mask becomes a read and ignores write-illegal.
  task automatic test_set_zero;
    req_valid = 1'b1; req_cmd = CMD_S; req_addr = 12'h300; req_wdata = 32'd0;
    tick; req_valid = 1'b0; csr_write_illegal = 1'b1;
    tick; csr_write_illegal = 1'b0; csr_rdata = 32'h55;
    n_cmp++; if (csr_cmd !== CMD_R) begin n_bad++; $display("FAIL sz_issue_cmd: got %0d want 1", csr_cmd); end
    tick; csr_rdata = 32'd0;
    n_cmp++; if (rsp_err !== ERR_OK) begin n_bad++; $display("FAIL sz_rsp_err: got %0d want 0", rsp_err); end
    n_cmp++; if (rsp_rdata !== 32'h55) begin n_bad++; $display("FAIL sz_rsp_rdata: got %h want 00000055", rsp_rdata); end
    tick;
  endtask

  // N goes straight to RESP in the next cycle.
  task automatic test_nop;
    req_valid = 1'b1; req_cmd = CMD_N; req_addr = 12'h123; req_wdata = 32'h9;
    tick; req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL nop_rsp_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL nop_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL nop_csr_cmd: got %0d want 0", csr_cmd); end
    tick;
  endtask

  // W with csr_stall held n cycles from the first ISSUE cycle.
  task automatic test_stall(input int n);
    req_valid = 1'b1; req_cmd = CMD_W; req_addr = 12'h340; req_wdata = 32'h12345678;
    tick; req_valid = 1'b0;
    tick;
    n_cmp++; if (csr_wdata !== 32'h12345678) begin n_bad++; $display("FAIL st%0d_wdata: got %h want 12345678", n, csr_wdata); end
    for (int c = 2; (c < 2 + n) && (c < 18); c++) begin
      n_cmp++; if (csr_cmd !== CMD_W) begin n_bad++; $display("FAIL st%0d_cmd_c%0d: got %0d want 2", n, c, csr_cmd); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL st%0d_rsp_c%0d: got %b want 0", n, c, rsp_valid); end
      csr_stall = 1'b1;
      tick;
    end
    if (n < 16) begin
      csr_stall = 1'b0; csr_rdata = 32'h70 + 32'(n);
      n_cmp++; if (csr_cmd !== CMD_W) begin n_bad++; $display("FAIL st%0d_commit_cmd: got %0d want 2", n, csr_cmd); end
      tick; csr_rdata = 32'd0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL st%0d_rsp_valid: got %b want 1", n, rsp_valid); end
      n_cmp++; if (rsp_err !== ERR_OK) begin n_bad++; $display("FAIL st%0d_rsp_err: got %0d want 0", n, rsp_err); end
      n_cmp++; if (rsp_rdata !== 32'h70 + 32'(n)) begin n_bad++; $display("FAIL st%0d_rsp_rdata: got %h want %h", n, rsp_rdata, 32'h70 + 32'(n)); end
    end else begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL st%0d_to_valid: got %b want 1", n, rsp_valid); end
      n_cmp++; if (rsp_err !== ERR_TIMEOUT) begin n_bad++; $display("FAIL st%0d_to_err: got %0d want 3", n, rsp_err); end
      n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL st%0d_to_rdata: got %h want 0", n, rsp_rdata); end
      csr_stall = 1'b0;
    end
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL st%0d_cmd_after: got %0d want 0", n, csr_cmd); end
    tick;
  endtask

  // Response back-pressure for 4 cycles with a second request waiting.
  task automatic test_back_to_back;
    req_valid = 1'b1; req_cmd = CMD_R; req_addr = 12'h301; req_wdata = 32'd0;
    tick; req_addr = 12'h302;
    tick; csr_rdata = 32'hDEAD; rsp_ready = 1'b0;
    tick; csr_rdata = 32'd0;
    for (int c = 3; c < 7; c++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_valid_c%0d: got %b want 1", c, rsp_valid); end
      n_cmp++; if (rsp_rdata !== 32'hDEAD) begin n_bad++; $display("FAIL b2b_hold_rdata_c%0d: got %h want 0000dead", c, rsp_rdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_ready_c%0d: got %b want 0", c, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hs_ready: got %b want 0", req_ready); end
    tick;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_after: got %b want 0", rsp_valid); end
    tick; req_valid = 1'b0;
    n_cmp++; if (csr_addr !== 12'h302) begin n_bad++; $display("FAIL b2b_second_addr: got %h want 302", csr_addr); end
    tick; csr_rdata = 32'hBEEF;
    tick; csr_rdata = 32'd0;
    n_cmp++; if (rsp_rdata !== 32'hBEEF) begin n_bad++; $display("FAIL b2b_second_rdata: got %h want 0000beef", rsp_rdata); end
    tick;
  endtask

  // Reset asserted mid-cycle while ISSUE is stalled.
  task automatic test_reset_mid;
    req_valid = 1'b1; req_cmd = CMD_W; req_addr = 12'h300; req_wdata = 32'h9;
    tick; req_valid = 1'b0;
    tick; csr_stall = 1'b1;
    n_cmp++; if (csr_cmd !== CMD_W) begin n_bad++; $display("FAIL rm_issue_cmd: got %0d want 2", csr_cmd); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (csr_cmd !== CMD_N) begin n_bad++; $display("FAIL rm_async_cmd: got %0d want 0", csr_cmd); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_async_ready: got %b want 1", req_ready); end
    @(negedge clk); rst_n = 1'b1; csr_stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp_c%0d: got %b want 0", c, rsp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_c%0d: got %b want 1", c, req_ready); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = CMD_N; req_addr = 12'd0; req_wdata = 32'd0;
    rsp_ready = 1'b1; csr_rdata = 32'd0; csr_stall = 1'b0;
    csr_read_illegal = 1'b0; csr_write_illegal = 1'b0;
    test_reset;
    test_read;
    test_write_illegal;
    test_read_illegal_priority;
    test_set_zero;
    test_nop;
    test_stall(3);
    test_stall(15);
    test_stall(16);
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter: STALL_TIMEOUT, 16, max consecutive csr_stall cycles tolerated in ISSUE (1..255).
REQ-002 SHALL have one clock and reset: asynchronous, active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  requester presents a CSR operation.
REQ-006 req_ready  output  1  unit accepts the request this cycle.
REQ-007 req_cmd  input  Bundle::ControlRegisterCommand  operation: N, R, W, S, C.
REQ-008 req_addr  input  12  CSR address.
REQ-009 req_wdata  input  32  write / set / clear operand.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes response.
REQ-012 rsp_rdata  output  32  CSR old value read during commit; 0 on error.
REQ-013 rsp_err  output  Bundle::CsrErr  OK=0, RD_ILL=1, WR_ILL=2, TIMEOUT=3.
REQ-014 csr_cmd  output  Bundle::ControlRegisterCommand  command to CSR file; N when idle.
REQ-015 csr_addr  output  12  CSR address to CSR file.
REQ-016 csr_wdata  output  32  operand to CSR file.
REQ-017 csr_rdata  input  32  CSR file read data.
REQ-018 csr_stall, csr_read_illegal, csr_write_illegal  input  1 each  CSR file status.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, ISSUE, RESP.
REQ-020 req_ready SHALL be 1 exactly in IDLE; accept = req_valid && req_ready; cmd/addr/wdata latched on accept.
REQ-021 Accepted cmd N SHALL go directly to RESP with rsp_err=OK, rsp_rdata=0, never driving csr_cmd.
REQ-022 S or C with req_wdata==0 SHALL be reclassified as R at accept (no write side effect, no write-legality check).
REQ-023 CHECK (1 cycle): csr_addr=latched addr, csr_cmd=N; all ops check csr_read_illegal; W/S/C also check csr_write_illegal.
REQ-024 Illegal in CHECK -> RESP with RD_ILL (priority) or WR_ILL; csr_cmd never leaves N for that transaction.
REQ-025 Legal in CHECK -> ISSUE; in ISSUE csr_cmd/csr_addr/csr_wdata SHALL be driven every cycle.
REQ-026 Commit = first ISSUE cycle with csr_stall=0; csr_rdata captured into rsp_rdata that cycle; next state RESP, rsp_err=OK.
REQ-027 Stall counter (8 bits) SHALL clear on entering ISSUE, increment each stalled ISSUE cycle; on reaching STALL_TIMEOUT -> RESP with TIMEOUT, csr_cmd=N next cycle.
REQ-028 Minimum latency: accept at cycle 0, CHECK 1, ISSUE/commit 2, rsp_valid at 3.
REQ-029 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then IDLE; rsp_ready ignored outside RESP.
REQ-030 csr_cmd SHALL be N in IDLE, CHECK and RESP; exactly one commit cycle per non-error transaction.
REQ-031 No new request accepted in the cycle the response handshakes (req_ready rises the following cycle).

Reset
REQ-032 rst_n low SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=OK, csr_cmd=N, csr_addr=0, csr_wdata=0, counter=0.
REQ-033 Reset mid-transaction SHALL abandon it with no response; if asserted during ISSUE, csr_cmd SHALL be N asynchronously.

Structure
REQ-034 Bundle package SHALL hold ControlRegisterCommand (existing) and new CsrErr enum; STALL_TIMEOUT stays a module parameter.
REQ-035 Single module, no sub-module; one FSM plus datapath registers.

Verification
REQ-036 R to 0x300, csr_rdata=0x1800, no stall -> rsp_valid cycle 3, rsp_rdata=0x1800, OK, one commit cycle.
REQ-037 W to 0xF11 with csr_write_illegal=1 in CHECK -> rsp_err=WR_ILL, rsp_rdata=0, csr_cmd always N.
REQ-038 S to 0x300, wdata=0, csr_write_illegal=1 -> issued as R, rsp_err=OK.
REQ-039 W with csr_stall held 3 cycles -> commit cycle 5, rsp_valid cycle 6, OK; stall held 16 cycles -> TIMEOUT, csr_cmd N after.
REQ-040 rsp_ready low 4 cycles in RESP -> rsp fields stable, req_ready=0; second req_valid accepted one cycle after handshake.
REQ-041 rst_n low during ISSUE -> csr_cmd N immediately, no rsp_valid, req_ready=1 after release.
